core_task_dispatcher: RTL

- Round-robin task dispatcher. It sits directly upstream of the next-free-core finder and consumes that finder's result.
- Accepts one task at a time from the global scheduler, then drives the finder with the current free-core mask and the last-served core ID.
- Issues the task to the selected core over a valid/ack handshake, then advances the round-robin pointer.
- Searches until a core is found and re-searches if the target core stops being free before it acknowledges.

---
 rtl/core_task_dispatcher.sv | 89 ++++++++
 1 files changed

// File: rtl/core_task_dispatcher.sv
// Round-robin task dispatcher: accepts one task at a time, asks the external
// next-free-core finder for a target, then issues over a per-core valid/ack.
module core_task_dispatcher #(
    parameter int NUM_OF_CORES = 16,
    parameter int CORE_ID_SIZE = 4,
    parameter int TASK_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    task_valid,
    input  logic [TASK_WIDTH-1:0]   task_data,
    output logic                    task_ready,
    input  logic [NUM_OF_CORES-1:0] core_free,
    output logic [NUM_OF_CORES-1:0] search_mask,
    output logic [CORE_ID_SIZE-1:0] search_start,
    input  logic [CORE_ID_SIZE:0]   search_result,
    output logic [NUM_OF_CORES-1:0] dispatch_valid,
    output logic [TASK_WIDTH-1:0]   dispatch_data,
    input  logic [NUM_OF_CORES-1:0] dispatch_ack,
    output logic [CORE_ID_SIZE-1:0] last_id,
    output logic [15:0]             stall_cnt
);
    // state  | meaning
    // IDLE   | waiting for an upstream task; task_ready high
    // SEARCH | finder consulted every cycle until it reports a free core
    // ISSUE  | dispatch_valid held on target until ack or target goes busy
    typedef enum logic [1:0] {IDLE, SEARCH, ISSUE} state_t;

    localparam logic [CORE_ID_SIZE-1:0] LAST_ID_RST = CORE_ID_SIZE'(NUM_OF_CORES - 1);
    localparam logic [NUM_OF_CORES-1:0] ONE_HOT_0   = NUM_OF_CORES'(1);

    state_t                  state;
    logic [CORE_ID_SIZE-1:0] target;
    logic [TASK_WIDTH-1:0]   task_q;

    assign search_mask   = core_free;
    assign search_start  = last_id;
    assign dispatch_data = task_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            task_ready     <= 1'b1;
            dispatch_valid <= '0;
            task_q         <= '0;
            target         <= '0;
            last_id        <= LAST_ID_RST;
            stall_cnt      <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (task_valid && task_ready) begin
                        task_q     <= task_data;
                        task_ready <= 1'b0;
                        state      <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (search_result[CORE_ID_SIZE]) begin
                        if (stall_cnt != 16'hFFFF) begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end else begin
                        target         <= search_result[CORE_ID_SIZE-1:0];
                        dispatch_valid <= ONE_HOT_0 << search_result[CORE_ID_SIZE-1:0];
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ack wins over a simultaneous busy indication
                    if (dispatch_ack[target]) begin
                        last_id        <= target;
                        dispatch_valid <= '0;
                        task_ready     <= 1'b1;
                        state          <= IDLE;
                    end else if (!core_free[target]) begin
                        dispatch_valid <= '0;
                        state          <= SEARCH;
                    end
                end
                default: begin
                    dispatch_valid <= '0;
                    task_ready     <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule
